// File: rtl/c17_trojan_scan_ctrl.sv
// Exhaustive c17 golden-vs-suspect scan controller: walks all input vectors,
// compares {N22,N23} after a settle window and streams one record per mismatch.
module c17_trojan_scan_ctrl #(
   parameter int NUM_IN        = 5,
   parameter int NUM_OUT       = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic [NUM_IN-1:0]  vec_out,
   input  logic [NUM_OUT-1:0] gold_out,
   input  logic [NUM_OUT-1:0] sus_out,
   output logic               busy,
   output logic               done,
   output logic               rec_valid,
   input  logic               rec_ready,
   output logic [NUM_IN-1:0]  rec_vec,
   output logic [NUM_OUT-1:0] rec_diff,
   output logic [CNT_W-1:0]   mismatch_cnt,
   output logic               first_fail_valid,
   output logic [NUM_IN-1:0]  first_fail_vec
);

   localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETTLE  = 3'd1;
   localparam logic [2:0] S_COMPARE = 3'd2;
   localparam logic [2:0] S_REPORT  = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [SC_W-1:0]    cnt_q, cnt_d;
   logic [NUM_IN-1:0]  vec_q, vec_d;
   logic [NUM_IN-1:0]  rec_vec_q, rec_vec_d;
   logic [NUM_OUT-1:0] rec_diff_q, rec_diff_d;
   logic               rec_valid_q, rec_valid_d;
   logic [CNT_W-1:0]   mcnt_q, mcnt_d;
   logic               ff_valid_q, ff_valid_d;
   logic [NUM_IN-1:0]  ff_vec_q, ff_vec_d;
   logic [NUM_OUT-1:0] diff;
   logic               adv;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      vec_d       = vec_q;
      rec_vec_d   = rec_vec_q;
      rec_diff_d  = rec_diff_q;
      rec_valid_d = rec_valid_q;
      mcnt_d      = mcnt_q;
      ff_valid_d  = ff_valid_q;
      ff_vec_d    = ff_vec_q;
      diff        = gold_out ^ sus_out;
      adv         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               vec_d      = '0;
               mcnt_d     = '0;
               ff_valid_d = 1'b0;
               ff_vec_d   = '0;
               cnt_d      = '0;
               state_d    = S_SETTLE;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + SC_W'(1);
            if (abort)
               state_d = S_IDLE;
            else if (cnt_q == SC_W'(SETTLE_CYCLES - 1))
               state_d = S_COMPARE;
         end
         S_COMPARE: begin
            // An abort still lets this vector's mismatch be counted and captured.
            if (diff != '0) begin
               mcnt_d = sat_inc(mcnt_q);
               if (!ff_valid_q) begin
                  ff_valid_d = 1'b1;
                  ff_vec_d   = vec_q;
               end
            end
            if (abort) begin
               state_d     = S_IDLE;
               rec_valid_d = 1'b0;
            end else if (diff != '0) begin
               rec_vec_d   = vec_q;
               rec_diff_d  = diff;
               rec_valid_d = 1'b1;
               state_d     = S_REPORT;
            end else begin
               adv = 1'b1;
            end
         end
         S_REPORT: begin
            if (abort) begin
               state_d     = S_IDLE;
               rec_valid_d = 1'b0;
            end else if (rec_ready) begin
               rec_valid_d = 1'b0;
               adv         = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (adv) begin
         if (&vec_q) begin
            state_d = S_DONE;
         end else begin
            vec_d   = vec_q + NUM_IN'(1);
            cnt_d   = '0;
            state_d = S_SETTLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         vec_q       <= '0;
         rec_vec_q   <= '0;
         rec_diff_q  <= '0;
         rec_valid_q <= 1'b0;
         mcnt_q      <= '0;
         ff_valid_q  <= 1'b0;
         ff_vec_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vec_q       <= vec_d;
         rec_vec_q   <= rec_vec_d;
         rec_diff_q  <= rec_diff_d;
         rec_valid_q <= rec_valid_d;
         mcnt_q      <= mcnt_d;
         ff_valid_q  <= ff_valid_d;
         ff_vec_q    <= ff_vec_d;
      end
   end

   assign vec_out          = vec_q;
   assign busy             = (state_q == S_SETTLE) || (state_q == S_COMPARE) || (state_q == S_REPORT);
   assign done             = (state_q == S_DONE);
   assign rec_valid        = rec_valid_q;
   assign rec_vec          = rec_vec_q;
   assign rec_diff         = rec_diff_q;
   assign mismatch_cnt     = mcnt_q;
   assign first_fail_valid = ff_valid_q;
   assign first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_c17_trojan_scan_ctrl.sv
// Bench for c17_trojan_scan_ctrl: scan scenario table, randomized suspects
// with a vector-level reference model, plus abort and reset sequences.
module tb_c17_trojan_scan_ctrl;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst, start, abort, rec_ready;
   logic [1:0] gold, sus;
   logic [4:0] vec_out, rec_vec, ff_vec;
   logic [1:0] rec_diff;
   logic       busy, done, rec_valid, ffv;
   logic [5:0] cnt6;
   logic [4:0] vec_out4, rec_vec4, ff_vec4;
   logic [1:0] rec_diff4;
   logic       busy4, done4, rec_valid4, ffv4;
   logic [3:0] cnt4;

   int         n_cmp = 0;
   int         n_fail = 0;
   int         mode = 0;
   logic [1:0] rmask [32];

   always #5 clk = ~clk;

   c17_trojan_scan_ctrl #(.NUM_IN(5), .NUM_OUT(2), .SETTLE_CYCLES(S), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec_out),
      .gold_out(gold), .sus_out(sus), .busy(busy), .done(done),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_vec(rec_vec), .rec_diff(rec_diff),
      .mismatch_cnt(cnt6), .first_fail_valid(ffv), .first_fail_vec(ff_vec));

   c17_trojan_scan_ctrl #(.NUM_IN(5), .NUM_OUT(2), .SETTLE_CYCLES(S), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec_out4),
      .gold_out(gold), .sus_out(sus), .busy(busy4), .done(done4),
      .rec_valid(rec_valid4), .rec_ready(rec_ready), .rec_vec(rec_vec4), .rec_diff(rec_diff4),
      .mismatch_cnt(cnt4), .first_fail_valid(ffv4), .first_fail_vec(ff_vec4));

   // c17 from its NAND netlist; input order {N1,N2,N3,N6,N7}
   function automatic logic [1:0] c17(input logic [4:0] v);
      logic n10, n11, n16, n19;
      n10 = ~(v[4] & v[2]);
      n11 = ~(v[2] & v[1]);
      n16 = ~(v[3] & n11);
      n19 = ~(n11 & v[0]);
      return {~(n10 & n16), ~(n16 & n19)};
   endfunction

   function automatic logic [1:0] sus_of(input int m, input logic [4:0] v);
      logic [1:0] g;
      g = c17(v);
      case (m)
         1:       return g ^ ((v == 5'd31) ? 2'b10 : 2'b00);
         2:       return ~g;
         3:       return g ^ ((v == 5'd3) ? 2'b01 : 2'b00);
         4:       return g ^ rmask[v];
         default: return g;
      endcase
   endfunction

   always_comb begin
      gold = c17(vec_out);
      sus  = sus_of(mode, vec_out);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle_zero(input string name);
      check({name, "_vec"},   vec_out, 0);
      check({name, "_busy"},  busy, 0);
      check({name, "_done"},  done, 0);
      check({name, "_rv"},    rec_valid, 0);
      check({name, "_rvec"},  rec_vec, 0);
      check({name, "_rdiff"}, rec_diff, 0);
      check({name, "_cnt6"},  cnt6, 0);
      check({name, "_cnt4"},  cnt4, 0);
      check({name, "_ffv"},   ffv, 0);
      check({name, "_ffvec"}, ff_vec, 0);
   endtask

   // rdy_mode: 0 = ready always, 1 = hold ready low for the first 10 record cycles,
   // 2 = random ready with random (ignored) start pulses. e_cyc < 0 derives it.
   task automatic run_scan(input int m, input int rdy_mode, input int e_cnt6, input int e_cnt4,
                           input int e_ffv, input int e_ffvec, input int e_nrec, input int e_cyc);
      logic [4:0] qv[$];
      logic [1:0] qd[$];
      logic [4:0] prev, acc_vec, st_vec, ev;
      logic [1:0] st_diff, ed;
      int         cyc, nrec, stalls, stall_left;
      bit         acc_pend, stall_pend;
      mode = m;
      for (int v = 0; v < 32; v++) begin
         ed = c17(5'(v)) ^ sus_of(m, 5'(v));
         if (ed != 2'b00) begin
            qv.push_back(5'(v));
            qd.push_back(ed);
         end
      end
      @(negedge clk);
      start = 1'b1;
      rec_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0; nrec = 0; stalls = 0; stall_left = 10;
      acc_pend = 0; stall_pend = 0; prev = 5'd0;
      check("scan_first_vec", vec_out, 0);
      while (!done && cyc < 3000) begin
         if (acc_pend) begin
            check("resume_vec", vec_out, acc_vec + 1);
            acc_pend = 0;
         end
         if (stall_pend) begin
            check("stall_rv", rec_valid, 1);
            check("stall_rvec", rec_vec, st_vec);
            check("stall_rdiff", rec_diff, st_diff);
            check("stall_vec", vec_out, st_vec);
            stall_pend = 0;
         end
         if (vec_out != prev) begin
            check("vec_step", vec_out, prev + 5'd1);
            prev = vec_out;
         end
         case (rdy_mode)
            1: begin
               if (rec_valid && stall_left > 0) begin
                  rec_ready = 1'b0;
                  stall_left--;
               end else begin
                  rec_ready = 1'b1;
               end
            end
            2: begin
               rec_ready = 1'($urandom_range(0, 1));
               start     = 1'($urandom_range(0, 1));
            end
            default: rec_ready = 1'b1;
         endcase
         if (rec_valid) begin
            if (rec_ready) begin
               nrec++;
               if (qv.size() > 0) begin
                  ev = qv.pop_front();
                  ed = qd.pop_front();
               end else begin
                  ev = 5'd0;
                  ed = 2'b00;
               end
               check("rec_vec", rec_vec, ev);
               check("rec_diff", rec_diff, ed);
               check("rec_hold_vec", vec_out, rec_vec);
               acc_pend = 1;
               acc_vec  = rec_vec;
            end else begin
               stalls++;
               stall_pend = 1;
               st_vec  = rec_vec;
               st_diff = rec_diff;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      rec_ready = 1'b1;
      check("done_seen", done, 1);
      if (e_cyc >= 0) check("scan_cycles", cyc, e_cyc);
      else            check("scan_cycles", cyc, 32 * (S + 1) + e_nrec + stalls);
      check("end_cnt6", cnt6, e_cnt6);
      check("end_cnt4", cnt4, e_cnt4);
      check("end_ffv", ffv, e_ffv);
      check("end_ffvec", ff_vec, e_ffvec);
      check("end_nrec", nrec, e_nrec);
      check("end_busy", busy, 0);
      check("end_vec", vec_out, 31);
      check("end_rv", rec_valid, 0);
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("post_busy", busy, 0);
   endtask

   typedef struct {
      int mode; int rdy; int cnt6; int cnt4; int ffv; int ffvec; int nrec; int cyc;
   } scan_t;

   scan_t tbl [4];

   initial begin
      int cyc, n, fv;
      tbl[0] = '{mode: 0, rdy: 0, cnt6: 0,  cnt4: 0,  ffv: 0, ffvec: 0,  nrec: 0,  cyc: 96};
      tbl[1] = '{mode: 1, rdy: 0, cnt6: 1,  cnt4: 1,  ffv: 1, ffvec: 31, nrec: 1,  cyc: 97};
      tbl[2] = '{mode: 2, rdy: 0, cnt6: 32, cnt4: 15, ffv: 1, ffvec: 0,  nrec: 32, cyc: 128};
      tbl[3] = '{mode: 3, rdy: 1, cnt6: 1,  cnt4: 1,  ffv: 1, ffvec: 3,  nrec: 1,  cyc: 107};
      for (int v = 0; v < 32; v++) rmask[v] = 2'b00;

      rst = 1'b1; start = 1'b0; abort = 1'b0; rec_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 4; i++)
         run_scan(tbl[i].mode, tbl[i].rdy, tbl[i].cnt6, tbl[i].cnt4,
                  tbl[i].ffv, tbl[i].ffvec, tbl[i].nrec, tbl[i].cyc);

      for (int r = 0; r < 3; r++) begin
         n = 0; fv = 0;
         for (int v = 0; v < 32; v++) begin
            rmask[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (rmask[v] != 2'b00) begin
               if (n == 0) fv = v;
               n++;
            end
         end
         run_scan(4, 2, (n > 63) ? 63 : n, (n > 15) ? 15 : n, (n > 0) ? 1 : 0, fv, n, -1);
      end

      // Abort while vec_out = 7: vectors 0..6 already counted, results retained
      mode = 2; rec_ready = 1'b1;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc = 0;
      while (vec_out != 5'd7 && cyc < 200) begin @(posedge clk); #1; cyc++; end
      check("abort_reach", vec_out, 7);
      abort = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_rv", rec_valid, 0);
      check("abort_cnt6", cnt6, 7);
      check("abort_ffv", ffv, 1);
      check("abort_ffvec", ff_vec, 0);
      repeat (3) begin
         @(posedge clk); #1;
         check("abort_idle_done", done, 0);
         check("abort_idle_busy", busy, 0);
      end
      abort = 1'b0;

      // Abort landing on a mismatching COMPARE: counted, no record
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc = 0;
      while (vec_out != 5'd2 && cyc < 200) begin @(posedge clk); #1; cyc++; end
      repeat (S) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_cmp_busy", busy, 0);
      check("abort_cmp_rv", rec_valid, 0);
      check("abort_cmp_cnt6", cnt6, 3);
      check("abort_cmp_cnt4", cnt4, 3);

      run_scan(0, 0, 0, 0, 0, 0, 0, 96);

      // Reset mid-REPORT with a coincident start
      mode = 2; rec_ready = 1'b0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc = 0;
      while (!rec_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
      check("rst_reach_report", rec_valid, 1);
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      check_idle_zero("rst_mid");
      rst = 1'b0; start = 1'b0; rec_ready = 1'b1;
      @(posedge clk); #1;
      check("rst_start_ignored", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/c17_trojan_scan_ctrl.md
Name: c17_trojan_scan_ctrl

Overview:
Sequential scheduler that exhaustively exercises the c17 benchmark. It drives one shared 5-bit input vector into a golden c17 instance and a suspect (possibly Trojan-inserted) c17 instance. After a settle window it compares their N22/N23 outputs and streams one record per mismatching vector. It sits between a test/host controller (start/done) and the two c17 netlists, replacing hand-written vector lists.

Parameters:
NUM_IN, 5, input vector width; bit order {N1,N2,N3,N6,N7}, N1 = MSB
NUM_OUT, 2, compared output width; bit order {N22,N23}, N22 = MSB
SETTLE_CYCLES, 2, clock cycles the vector is held before compare; legal range >= 1
CNT_W, 6, width of the saturating mismatch counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  begin a scan; sampled only in IDLE
abort  in  1  terminate the scan; return to IDLE next cycle
vec_out  out  NUM_IN  vector driven to both c17 instances
gold_out  in  NUM_OUT  golden {N22,N23}
sus_out  in  NUM_OUT  suspect {N22,N23}
busy  out  1  high in every state except IDLE and DONE
done  out  1  one-cycle pulse at scan completion
rec_valid  out  1  mismatch record valid
rec_ready  in  1  consumer accepts record
rec_vec  out  NUM_IN  failing vector
rec_diff  out  NUM_OUT  gold_out XOR sus_out at compare
mismatch_cnt  out  CNT_W  mismatching vectors this scan; saturates
first_fail_valid  out  1  at least one mismatch seen this scan
first_fail_vec  out  NUM_IN  first failing vector

Behaviour:
- Reset (rst=1 at an edge): state IDLE. All outputs 0: vec_out, busy, done, rec_valid, rec_vec, rec_diff, mismatch_cnt, first_fail_valid, first_fail_vec. Settle counter 0. Reset wins over start and abort in the same cycle, including mid-scan.
- State machine has five states: IDLE, SETTLE, COMPARE, REPORT, DONE.
- IDLE:
  - With start=1: vec_out<=0, mismatch_cnt<=0, first_fail_valid<=0, first_fail_vec<=0, settle counter<=0, go to SETTLE.
  - Results from the previous scan hold until then.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, go to COMPARE.
- COMPARE: diff = gold_out ^ sus_out, sampled this cycle.
  - If diff != 0:
    - mismatch_cnt += 1, holding at 2^CNT_W-1 once reached.
    - If first_fail_valid==0: first_fail_vec<=vec_out, first_fail_valid<=1.
    - rec_vec<=vec_out, rec_diff<=diff, rec_valid<=1, go to REPORT.
  - Otherwise ADVANCE.
- REPORT:
  - rec_valid, rec_vec and rec_diff stay stable until rec_ready=1.
  - On that edge: rec_valid<=0, then ADVANCE.
  - vec_out is held throughout.
- ADVANCE (transition, not a state):
  - If vec_out is all ones, go to DONE.
  - Else vec_out<=vec_out+1, counter<=0, go to SETTLE.
  - No wrap-around; each vector is visited exactly once, in ascending order.
- DONE: done=1 for exactly one cycle, then IDLE. vec_out keeps its last value (all ones).
- Latency with no mismatches: SETTLE_CYCLES+1 cycles per vector. Total = 2^NUM_IN*(SETTLE_CYCLES+1) cycles from the start-sampling edge to entry into DONE. Defaults: 96 cycles, with done high after edge 96. Each mismatch adds 1 cycle plus the rec_ready stall.
- abort=1 in SETTLE, COMPARE or REPORT:
  - Next state IDLE; rec_valid<=0; no done pulse.
  - mismatch_cnt and first_fail_* keep their values.
  - If abort coincides with a mismatch in COMPARE, the mismatch is counted and captured but no record is issued.
- start while busy is ignored. abort in IDLE or DONE is ignored.

Test Plan:
- Identical gold/sus models, start pulse: done after 96 cycles; mismatch_cnt=0; first_fail_valid=0; rec_valid never high; vec_out steps 0..31 ascending.
- Suspect = c17 Trojan triggered on vector 5'b11111, flipping N22; rec_ready tied 1: exactly one record with rec_vec=5'h1F and rec_diff=2'b10; mismatch_cnt=1; first_fail_vec=5'h1F; done after 97 cycles.
- sus_out forced to ~gold_out, CNT_W=4, rec_ready=1: 32 records with rec_diff=2'b11; mismatch_cnt saturates at 15; first_fail_vec=0.
- Mismatch at vector 3 with rec_ready held 0 for 10 cycles: rec_valid, rec_vec=3 and vec_out=3 stay stable; scan resumes at vector 4 the cycle after rec_ready=1.
- abort asserted while vec_out=7: IDLE next cycle; busy=0; no done pulse. A following start restarts from vector 0 with counters cleared.
- rst asserted mid-REPORT: all outputs 0 next cycle. A start in the same cycle as rst is ignored.
